// File: rtl/sum3_accumulator.sv
// ============================================================================
// Module   : sum3_accumulator
// Purpose  : Frames N_SAMPLES 10-bit sums into a total, a maximum and an
//            overflow flag, presented through a valid/ready handshake.
// Config   : define ACC_SAT_EN to clamp the accumulator on overflow
//            instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum3_accumulator #(
   parameter int N_SAMPLES = 8,   // 1..255
   parameter int ACC_W     = 13   // 10..32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [9:0]       in_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_total,
   output logic [9:0]       out_max,
   output logic             out_ovf
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [7:0] C_N = 8'(N_SAMPLES);
`ifdef ACC_SAT_EN
   localparam logic [ACC_W-1:0] C_ACC_MAX = '1;
`endif

   state_t           state_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [9:0]       max_q, max_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             w_accept;
   logic             w_last;
   logic [ACC_W:0]   w_sum;

   always_comb begin
      w_accept = in_valid & in_ready_q;
      // One extra bit so the carry out of the add marks an overflow.
      w_sum    = {1'b0, acc_q} + (ACC_W+1)'(in_sum);
      if (state_q == S_IDLE) begin
         acc_d = ACC_W'(in_sum);
         max_d = in_sum;
         cnt_d = 8'd1;
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q | w_sum[ACC_W];
`ifdef ACC_SAT_EN
         acc_d = ovf_d ? C_ACC_MAX : w_sum[ACC_W-1:0];
`else
         acc_d = w_sum[ACC_W-1:0];
`endif
         max_d = (in_sum >= max_q) ? in_sum : max_q;
         cnt_d = cnt_q + 8'd1;
      end
      w_last = (cnt_d == C_N);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         max_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_ACCUM: begin
               if (w_accept) begin
                  acc_q <= acc_d;
                  max_q <= max_d;
                  cnt_q <= cnt_d;
                  ovf_q <= ovf_d;
                  if (w_last) begin
                     state_q     <= S_DONE;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= S_ACCUM;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Accumulator state is frozen in DONE, so it serves directly as the result.
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_total = acc_q;
   assign out_max   = max_q;
   assign out_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: doc/sum3_accumulator.md
SUM3_ACCUMULATOR -- requirements
Module: sum3_accumulator

Interface
REQ-001 Parameter N_SAMPLES, default 8, is the number of samples per frame; the legal range SHALL be 1..255.
REQ-002 Parameter ACC_W, default 13, is the accumulator and total width; the legal range SHALL be 10..32.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: in_sum is valid.
REQ-006 Port in_ready, output, 1 bit: the block can accept a sample.
REQ-007 Port in_sum, input, 10 bits: unsigned sample, i.e. the 10-bit adder-tree total.
REQ-008 Port out_valid, output, 1 bit: the frame result is valid.
REQ-009 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 Port out_total, output, ACC_W bits: unsigned sum of the frame's samples.
REQ-011 Port out_max, output, 10 bits: largest sample in the frame.
REQ-012 Port out_ovf, output, 1 bit: the accumulator overflowed at least once in the frame.

Function
REQ-013 A sample SHALL be accepted only on a cycle where in_valid and in_ready are both 1; in_sum is ignored at all other times.
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-015 IDLE: in_ready=1 and out_valid=0; on accept, acc=in_sum, max=in_sum, cnt=1, ovf=0; next state is DONE if N_SAMPLES==1, else ACCUM.
REQ-016 ACCUM: in_ready=1; on accept, acc=acc+in_sum, max=max(max,in_sum), cnt=cnt+1; when the accepted sample is number N_SAMPLES, next state is DONE.
REQ-017 ACCUM with no accept: all state SHALL hold; there is no timeout.
REQ-018 DONE: in_ready=0 and out_valid=1; out_total, out_max and out_ovf SHALL be driven from registers and held stable until out_ready=1.
REQ-019 DONE with out_ready=1: the result SHALL be consumed, next state is IDLE, and in_ready=1 from the following cycle; there is no same-cycle bypass.
REQ-020 Latency: out_valid SHALL rise on the cycle after the edge that accepts sample N_SAMPLES.
REQ-021 Sustained throughput: N_SAMPLES samples per N_SAMPLES+1 cycles when out_ready is held at 1.
REQ-022 Overflow is defined as the true sum exceeding 2^ACC_W-1; on overflow out_ovf SHALL become 1 and stay 1 until the next frame starts.
REQ-023 out_max SHALL take the value of an equal sample (ties keep the same value).
REQ-024 A tie with in_sum=0 SHALL still count as a sample.
REQ-025 With ACC_W >= 10+ceil(log2(N_SAMPLES)), overflow SHALL be unreachable.

Reset
REQ-026 With reset_n=0 at a rising edge, the FSM SHALL go to IDLE and acc, max, cnt, ovf, out_total, out_max and out_ovf SHALL all be 0.
REQ-027 During reset, out_valid SHALL be 0, and in_ready SHALL be 1 from the first cycle after reset_n is released.
REQ-028 Reset in ACCUM or DONE SHALL abort the frame; the partial or pending result is discarded and never presented.

Configuration
REQ-029 Macro ACC_SAT_EN defined: on overflow, acc SHALL clamp to 2^ACC_W-1 and stay there for the rest of the frame.
REQ-030 Macro ACC_SAT_EN undefined: acc SHALL wrap modulo 2^ACC_W.
REQ-031 out_ovf SHALL behave identically in both builds.

Verification
REQ-032 N_SAMPLES=4, ACC_W=13, samples 259,42,176,99 back-to-back, out_ready=1 -> out_valid one cycle after the 4th accept; out_total=576, out_max=259, out_ovf=0.
REQ-033 Same frame, out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0 throughout; the handshake completes on the first cycle out_ready=1, then IDLE.
REQ-034 in_valid gaps of 3 cycles between samples 3,0,15,15 (N=4) -> total=33, max=15; cnt does not advance on idle cycles.
REQ-035 ACC_W=10, N=4, four samples of 1023 -> with ACC_SAT_EN: total=1023, ovf=1; without: total=1020, ovf=1.
REQ-036 reset_n=0 after 2 accepts, then a fresh 4-sample frame 1,2,3,4 -> total=10, max=4, ovf=0, and no stale result appears.
REQ-037 N_SAMPLES=1, sample 500 -> DONE the next cycle; total=500, max=500.
